// File: rtl/pattern_detect_0110.sv
// Serial sequence detector: pulses z for one cycle whenever the last PATTERN_LEN sampled
// bits of x equal PATTERN (MSB oldest). Overlapping matches are optional.
module pattern_detect_0110 #(
  parameter int unsigned PATTERN_LEN = 4,
  parameter logic [15:0] PATTERN     = 16'b0110,
  parameter bit          OVERLAP     = 1'b1
) (
  output logic z,
  input  logic x,
  input  logic clk,
  input  logic rst
);

  if ((PATTERN_LEN < 2) || (PATTERN_LEN > 16)) begin : g_bad_len
    $error("pattern_detect_0110: PATTERN_LEN must be in 2..16");
  end

  localparam int unsigned             CntW   = $clog2(PATTERN_LEN + 1);
  localparam logic [PATTERN_LEN-1:0]  Target = PATTERN[PATTERN_LEN-1:0];
  localparam logic [CntW-1:0]         CntMax = CntW'(PATTERN_LEN);

  logic [PATTERN_LEN-1:0] hist_q, hist_d;
  logic [CntW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                   z_q;
  logic                   match;

  always_comb begin
    hist_d  = {hist_q[PATTERN_LEN-2:0], x};
    cnt_inc = (cnt_q == CntMax) ? CntMax : cnt_q + CntW'(1);
    // Zero-filled history is not data: only compare once a full window has been sampled.
    match   = (cnt_inc == CntMax) && (hist_d == Target);
    cnt_d   = (match && !OVERLAP) ? '0 : cnt_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      cnt_q  <= '0;
      z_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
      z_q    <= match;
    end
  end

  assign z = z_q;

endmodule

// File: tb/tb_pattern_detect_0110.sv
// Directed bench for pattern_detect_0110: checks an overlapping and a non-overlapping
// instance side by side against hand-computed pulse positions.
module tb_pattern_detect_0110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x   = 1'b0;
  logic z, zn;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pattern_detect_0110 dut (
    .z   (z),
    .x   (x),
    .clk (clk),
    .rst (rst)
  );

  pattern_detect_0110 #(
    .OVERLAP (1'b0)
  ) dut_no_ov (
    .z   (zn),
    .x   (x),
    .clk (clk),
    .rst (rst)
  );

  typedef struct {
    logic x;
    logic z;
    logic zn;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  // Drive one bit, let the edge sample it, compare just after the edge.
  task automatic send_bit(input string name, input int idx, input logic b,
                          input logic ez, input logic ezn);
    x = b;
    @(posedge clk);
    #1;
    chk(name, idx, z, ez);
    chk({name, "_no_ov"}, idx, zn, ezn);
    #1;
  endtask

  task automatic run_seq(input string name, input logic [31:0] bits, input int n,
                         input logic [31:0] e, input logic [31:0] en);
    for (int i = 0; i < n; i++) begin
      send_bit(name, i + 1, bits[n-1-i], e[n-1-i], en[n-1-i]);
    end
  endtask

  // Asynchronous assert between edges, hold for two edges with x toggling, release.
  task automatic do_reset(input string name);
    rst = 1'b0;
    #1;
    chk({name, "_async"}, 0, z, 1'b0);
    chk({name, "_async_no_ov"}, 0, zn, 1'b0);
    for (int i = 0; i < 2; i++) begin
      x = ~x;
      @(posedge clk);
      #1;
      chk({name, "_hold"}, i, z, 1'b0);
      chk({name, "_hold_no_ov"}, i, zn, 1'b0);
      #1;
    end
    rst = 1'b1;
    #1;
    chk({name, "_release"}, 0, z, 1'b0);
    chk({name, "_release_no_ov"}, 0, zn, 1'b0);
  endtask

  initial begin
    logic [19:0] s_bits;
    logic [19:0] s_z;
    logic [19:0] s_zn;
    s_bits = 20'b0011_0100_0110_1100_1111;
    s_z    = 20'b0000_1000_0001_0010_0000;  // pulses after bits 5, 12, 15
    s_zn   = 20'b0000_1000_0001_0000_0000;  // third match overlaps, so dropped
    for (int i = 0; i < 20; i++) begin
      vecs[i] = '{x: s_bits[19-i], z: s_z[19-i], zn: s_zn[19-i]};
    end

    #1;
    do_reset("reset");

    for (int i = 0; i < 20; i++) begin
      send_bit("stream", i + 1, vecs[i].x, vecs[i].z, vecs[i].zn);
    end

    do_reset("reset2");
    run_seq("overlap", 32'b0110110, 7, 32'b0001001, 32'b0001000);

    // z is high here; the reset must clear it without a clock edge.
    do_reset("reset_z_high");
    run_seq("startup_110", 32'b110, 3, 32'b000, 32'b000);

    do_reset("reset3");
    run_seq("near_miss", 32'b0111_0100_1110_0111_0100_1110, 24, 32'd0, 32'd0);

    do_reset("reset4");
    run_seq("mid_pre", 32'b011, 3, 32'b000, 32'b000);
    do_reset("mid_reset");
    run_seq("mid_post", 32'b0, 1, 32'b0, 32'b0);
    run_seq("mid_after", 32'b0110, 4, 32'b0001, 32'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
